pwm_ramp_sequencer: RTL and testbench

Command-driven controller for the team's duty-cycle/frequency PWM generator. It owns that generator's `En`, `dutyCycle` and `Frequency` inputs. It accepts duty/frequency/stop commands over a valid/ready handshake and ramps the duty cycle one eighth-step at a time with a programmable dwell, so the load never sees abrupt jumps. Frequency changes are applied only at zero duty, and stop requests ramp down before disabling the generator.

---
 rtl/pwm_ramp_sequencer_if.sv | 24 ++
 rtl/pwm_ramp_sequencer.sv | 151 +++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// Command handshake and generator drive bundle for pwm_ramp_sequencer.
// The master side issues commands; the slave side is the sequencer.
interface pwm_ramp_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_duty;
   logic [1:0] cmd_freq;
   logic       cmd_stop;
   logic       pwm_en;
   logic [3:0] pwm_duty;
   logic [1:0] pwm_freq;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid, cmd_duty, cmd_freq, cmd_stop,
      input  cmd_ready, pwm_en, pwm_duty, pwm_freq, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_duty, cmd_freq, cmd_stop,
      output cmd_ready, pwm_en, pwm_duty, pwm_freq, busy, done
   );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Command-driven controller for the 1/8-resolution PWM generator: duty moves
// one code per dwell period, and frequency only changes while duty is zero.
module pwm_ramp_sequencer #(
   parameter int STEP_CYCLES = 250000,
   parameter int DUTY_MAX    = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   pwm_ramp_sequencer_if.slave bus
);
   localparam int              CW         = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0]   COUNT_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [3:0]      DUTY_TOP   = 4'(DUTY_MAX);

   // DECODE sits between accept and the first working state so the command
   // is evaluated against registered values one edge after the handshake.
   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      RAMP_DOWN,
      SWITCH,
      RAMP,
      FINISH
   } state_t;

   state_t        state_reg, state_next;
   logic [3:0]    duty_reg, duty_next;
   logic [1:0]    freq_reg, freq_next;
   logic          en_reg, en_next;
   logic [CW-1:0] count_reg, count_next;
   logic [3:0]    target_reg, target_next;
   logic [1:0]    freq_tgt_reg, freq_tgt_next;
   logic          stop_reg, stop_next;

   logic          dwell_done;
   logic [3:0]    duty_up;
   logic [3:0]    duty_dn;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg    <= IDLE;
         duty_reg     <= 4'd0;
         freq_reg     <= 2'd0;
         en_reg       <= 1'b0;
         count_reg    <= '0;
         target_reg   <= 4'd0;
         freq_tgt_reg <= 2'd0;
         stop_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         duty_reg     <= duty_next;
         freq_reg     <= freq_next;
         en_reg       <= en_next;
         count_reg    <= count_next;
         target_reg   <= target_next;
         freq_tgt_reg <= freq_tgt_next;
         stop_reg     <= stop_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      duty_next     = duty_reg;
      freq_next     = freq_reg;
      en_next       = en_reg;
      count_next    = count_reg;
      target_next   = target_reg;
      freq_tgt_next = freq_tgt_reg;
      stop_next     = stop_reg;
      dwell_done    = (count_reg == COUNT_LAST);
      duty_up       = duty_reg + 4'd1;
      duty_dn       = duty_reg - 4'd1;

      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               target_next   = (bus.cmd_duty > DUTY_TOP) ? DUTY_TOP : bus.cmd_duty;
               freq_tgt_next = bus.cmd_freq;
               stop_next     = bus.cmd_stop;
               state_next    = DECODE;
            end
         end

         DECODE: begin
            count_next = '0;
            if (stop_reg) begin
               state_next = (duty_reg != 4'd0) ? RAMP_DOWN : FINISH;
            end else begin
               en_next = 1'b1;
               if (freq_tgt_reg != freq_reg)
                  state_next = (duty_reg != 4'd0) ? RAMP_DOWN : SWITCH;
               else
                  state_next = (duty_reg != target_reg) ? RAMP : FINISH;
            end
         end

         RAMP_DOWN: begin
            if (dwell_done) begin
               count_next = '0;
               if (duty_reg != 4'd0)
                  duty_next = duty_dn;
               if (duty_reg <= 4'd1)
                  state_next = stop_reg ? FINISH : SWITCH;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end

         SWITCH: begin
            freq_next  = freq_tgt_reg;
            count_next = '0;
            state_next = (target_reg == 4'd0) ? FINISH : RAMP;
         end

         RAMP: begin
            if (dwell_done) begin
               count_next = '0;
               // Target is already clamped, so stepping toward it cannot overshoot.
               if (duty_reg < target_reg && duty_reg < DUTY_TOP) begin
                  duty_next = duty_up;
                  if (duty_up == target_reg)
                     state_next = FINISH;
               end else if (duty_reg > target_reg) begin
                  duty_next = duty_dn;
                  if (duty_dn == target_reg)
                     state_next = FINISH;
               end else begin
                  state_next = FINISH;
               end
            end else begin
               count_next = count_reg + 1'b1;
            end
         end

         FINISH: begin
            if (stop_reg)
               en_next = 1'b0;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = (state_reg == FINISH);
   assign bus.pwm_en    = en_reg;
   assign bus.pwm_duty  = duty_reg;
   assign bus.pwm_freq  = freq_reg;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Randomized bench for pwm_ramp_sequencer; expected outputs come from a
// phase-timing model of each command evaluated per cycle after accept.
module tb_pwm_ramp_sequencer;
   localparam int STEP = 4;
   localparam int DMAX = 8;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   pwm_ramp_sequencer_if bus ();

   pwm_ramp_sequencer #(.STEP_CYCLES(STEP), .DUTY_MAX(DMAX)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   int m_duty   = 0;
   int m_freq   = 0;
   int m_en     = 0;
   int max_duty = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // {ready, busy, done, en, duty[3:0], freq[1:0]}
   function automatic logic [9:0] observed();
      return {bus.cmd_ready, bus.busy, bus.done, bus.pwm_en, bus.pwm_duty, bus.pwm_freq};
   endfunction

   task automatic run_cmd(input int duty_raw, input int freq, input bit stop,
                          input bit hold, input int nduty, input int nfreq, input bit nstop);
      int t, d0, f0, e0, ks, base, up_n, dir, fin_k, sw_k, down_n;
      int e_duty, e_freq, e_en;
      logic [9:0] exp_v, obs_v;
      t  = (duty_raw > DMAX) ? DMAX : duty_raw;
      d0 = m_duty; f0 = m_freq; e0 = m_en;
      if (stop) begin
         down_n = d0; ks = 1 << 30; base = 0; up_n = 0; dir = 0; sw_k = -1;
         fin_k = 1 + d0 * STEP;
      end else if (freq != f0) begin
         down_n = d0; sw_k = 2 + d0 * STEP; ks = sw_k; base = 0; up_n = t; dir = 1;
         fin_k = ks + t * STEP;
      end else begin
         down_n = 0; sw_k = -1; ks = 1; base = d0;
         up_n = (t > d0) ? t - d0 : d0 - t;
         dir  = (t > d0) ? 1 : -1;
         fin_k = 1 + up_n * STEP;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_duty  = 4'(duty_raw);
      bus.cmd_freq  = 2'(freq);
      bus.cmd_stop  = stop;
      @(posedge Clk); #1;
      if (hold) begin
         bus.cmd_duty = 4'(nduty);
         bus.cmd_freq = 2'(nfreq);
         bus.cmd_stop = nstop;
      end else begin
         bus.cmd_valid = 1'b0;
      end
      for (int k = 0; k <= fin_k + 1; k++) begin
         if (k > 0) begin
            @(posedge Clk); #1;
         end
         if (k < ks)
            e_duty = d0 - ((k < 1) ? 0 : imin(down_n, (k - 1) / STEP));
         else
            e_duty = base + dir * imin(up_n, (k - ks) / STEP);
         e_freq = (sw_k >= 0 && k >= sw_k) ? freq : f0;
         if (stop) e_en = (k >= fin_k + 1) ? 0 : e0;
         else      e_en = (k >= 1) ? 1 : e0;
         exp_v = {(k > fin_k), (k <= fin_k), (k == fin_k), e_en[0], 4'(e_duty), 2'(e_freq)};
         obs_v = observed();
         if (int'(bus.pwm_duty) > max_duty) max_duty = int'(bus.pwm_duty);
         checks++;
         if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL cmd_cycle k=%0d (duty=%0d freq=%0d stop=%0d): got rdy/busy/done/en/duty/freq=%b required %b",
                     k, duty_raw, freq, stop, obs_v, exp_v);
         end
      end
      $display("cmd duty=%0d freq=%0d stop=%0d hold=%0d : duty %0d->%0d freq %0d->%0d, %0d cycles",
               duty_raw, freq, stop, hold, d0, stop ? 0 : t, f0, stop ? f0 : freq, fin_k + 2);
      m_duty = stop ? 0 : t;
      m_freq = stop ? f0 : freq;
      m_en   = stop ? 0 : 1;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.cmd_duty = 4'd0; bus.cmd_freq = 2'd0; bus.cmd_stop = 1'b0;
      Rst = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (observed() !== 10'b1000000000) begin
         failures++;
         $display("FAIL reset_state: got %b required %b", observed(), 10'b1000000000);
      end
      #2 Rst = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (observed() !== 10'b1000000000) begin
         failures++;
         $display("FAIL idle_after_reset: got %b required %b", observed(), 10'b1000000000);
      end
      m_duty = 0; m_freq = 0; m_en = 0;
      $display("reset: outputs idle");
   endtask

   task automatic test_ramp_up();
      run_cmd(5, 0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_ramp_down_clamp();
      run_cmd(3, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
      max_duty = 0;
      run_cmd(12, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
      repeat (3 * STEP) @(posedge Clk);
      #1;
      if (int'(bus.pwm_duty) > max_duty) max_duty = int'(bus.pwm_duty);
      checks++;
      if (max_duty !== DMAX) begin
         failures++;
         $display("FAIL clamp_max: got peak duty %0d required %0d", max_duty, DMAX);
      end
   endtask

   task automatic test_freq_change();
      run_cmd(4, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
      run_cmd(2, (m_freq == 3) ? 0 : 3, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_stop();
      run_cmd(3, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
      run_cmd(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
      run_cmd(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      // The held duty=6 command must be taken on the first ready edge.
      run_cmd(2, m_freq, 1'b0, 1'b1, 6, m_freq, 1'b0);
      run_cmd(6, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
      run_cmd(6, m_freq, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_random();
      int d, f;
      bit s;
      for (int i = 0; i < 30; i++) begin
         s = ($urandom_range(0, 4) == 0);
         d = $urandom_range(0, 15);
         f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : m_freq;
         run_cmd(d, f, s, 1'b0, 0, 0, 1'b0);
      end
   endtask

   task automatic test_reset_mid_ramp();
      bit found;
      run_cmd(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
      bus.cmd_valid = 1'b1; bus.cmd_duty = 4'd8; bus.cmd_freq = 2'(m_freq); bus.cmd_stop = 1'b0;
      @(posedge Clk); #1;
      bus.cmd_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge Clk); #1;
         if (bus.pwm_duty == 4'd4) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL mid_ramp_reach: got duty %0d required 4 within 100 cycles", bus.pwm_duty);
      end
      #2 Rst = 1'b0;
      #1;
      checks++;
      if (observed() !== 10'b1000000000) begin
         failures++;
         $display("FAIL async_reset: got %b required %b", observed(), 10'b1000000000);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         checks++;
         if (observed() !== 10'b1000000000) begin
            failures++;
            $display("FAIL held_reset: got %b required %b", observed(), 10'b1000000000);
         end
      end
      #2 Rst = 1'b1;
      m_duty = 0; m_freq = 0; m_en = 0;
      $display("reset mid-ramp at duty 4: outputs cleared");
      @(posedge Clk); #1;
      run_cmd(2, 1, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down_clamp();
      test_freq_change();
      test_stop();
      test_back_to_back();
      test_random();
      test_reset_mid_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
